// File: rtl/z_exception_unit.sv
// z_exception_unit: prioritised execute-stage exception detection with a latched trap record,
// req/ack handoff, optional vectored handler address, saturating counter and sticky double-fault flag.
module z_exception_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int PC_WIDTH    = 32,
  parameter int CAUSE_WIDTH = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int VEC_EXC     = 0
) (
  input  logic                   z_clk,
  input  logic                   z_rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   debug_mode_valid_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic [31:0]            instr_i,
  input  logic                   branch_valid_i,
  input  logic [PC_WIDTH-1:0]    branch_pc_i,
  input  logic                   invalid_instr_valid_i,
  input  logic                   breakpoint_valid_i,
  input  logic                   ecall_valid_i,
  input  logic                   ld_valid_i,
  input  logic                   sd_valid_i,
  input  logic [DATA_WIDTH-1:0]  ld_sd_addr_i,
  input  logic [1:0]             byte_sel_i,
  input  logic                   mem_addr_invalid_i,
  input  logic [DATA_WIDTH-1:0]  data_mem_max_addr_i,
  input  logic [DATA_WIDTH-1:0]  csr_mtvec_i,
  input  logic                   trap_ack_i,
  input  logic                   exc_cnt_clr_i,
  output logic                   trap_req_o,
  output logic [CAUSE_WIDTH-1:0] trap_cause_o,
  output logic [DATA_WIDTH-1:0]  trap_tval_o,
  output logic [PC_WIDTH-1:0]    trap_epc_o,
  output logic [DATA_WIDTH-1:0]  trap_handler_addr_o,
  output logic                   double_fault_o,
  output logic [CNT_WIDTH-1:0]   exc_count_o
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t r_state, w_next;
  logic [CAUSE_WIDTH-1:0] r_cause, w_cause;
  logic [DATA_WIDTH-1:0]  r_tval, w_tval, w_base;
  logic [PC_WIDTH-1:0]    r_epc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic r_df;
  logic w_imis, w_mis, w_oob, w_ld, w_lmis, w_smis, w_lflt, w_sflt, w_any, w_capture, w_latch, w_dfault;
  // Byte accesses never misalign; wider ones need their low address bits clear
  assign w_mis = byte_sel_i == 2'b01 ? ld_sd_addr_i[0] :
                 byte_sel_i == 2'b10 ? |ld_sd_addr_i[1:0] :
                 byte_sel_i == 2'b11 ? |ld_sd_addr_i[2:0] : 1'b0;
  assign w_oob     = (ld_sd_addr_i > data_mem_max_addr_i) | mem_addr_invalid_i;
  assign w_imis    = branch_valid_i & |branch_pc_i[1:0];
  assign w_ld      = ld_valid_i & ~stall_i;
  assign w_lmis    = w_ld & w_mis;
  assign w_smis    = sd_valid_i & w_mis;
  assign w_lflt    = w_ld & ~w_mis & w_oob;
  assign w_sflt    = sd_valid_i & ~w_mis & w_oob;
  assign w_any     = |{w_imis, invalid_instr_valid_i, breakpoint_valid_i, ecall_valid_i, w_lmis, w_smis, w_lflt, w_sflt};
  assign w_capture = w_any & ~flush_i & ~debug_mode_valid_i;
  always_comb begin
    w_cause = w_imis ? CAUSE_WIDTH'(0) : invalid_instr_valid_i ? CAUSE_WIDTH'(2) :
              breakpoint_valid_i ? CAUSE_WIDTH'(3) : ecall_valid_i ? CAUSE_WIDTH'(11) :
              w_lmis ? CAUSE_WIDTH'(4) : w_smis ? CAUSE_WIDTH'(6) :
              w_lflt ? CAUSE_WIDTH'(5) : CAUSE_WIDTH'(7);
    w_tval  = w_imis ? DATA_WIDTH'(branch_pc_i) : invalid_instr_valid_i ? DATA_WIDTH'(instr_i) :
              breakpoint_valid_i ? DATA_WIDTH'(pc_i) : ecall_valid_i ? '0 : ld_sd_addr_i;
  end
  always_comb begin
    w_latch  = w_capture & (r_state == IDLE | trap_ack_i);
    w_dfault = w_capture & r_state == PENDING & ~trap_ack_i;
    w_next   = w_latch ? PENDING : (r_state == PENDING & trap_ack_i) ? IDLE : r_state;
  end
  always_ff @(posedge z_clk or negedge z_rst)
    if (!z_rst) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_tval  <= '0;
      r_epc   <= '0;
      r_cnt   <= '0;
      r_df    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_cause <= w_cause;
        r_tval  <= w_tval;
        r_epc   <= pc_i;
      end
      r_cnt <= exc_cnt_clr_i ? '0 : (w_latch & ~&r_cnt) ? r_cnt + CNT_WIDTH'(1) : r_cnt;
      r_df  <= ~exc_cnt_clr_i & (r_df | w_dfault);
    end
  assign w_base              = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
  assign trap_handler_addr_o = (VEC_EXC == 1 && csr_mtvec_i[1:0] == 2'b01) ?
                               w_base + (DATA_WIDTH'(r_cause) << 2) : w_base;
  assign trap_req_o     = r_state == PENDING;
  assign trap_cause_o   = r_cause;
  assign trap_tval_o    = r_tval;
  assign trap_epc_o     = r_epc;
  assign double_fault_o = r_df;
  assign exc_count_o    = r_cnt;
endmodule

// File: tb/tb_z_exception_unit.sv
// tb_z_exception_unit: directed scenarios plus randomized traffic against a behavioural trap model.
module tb_z_exception_unit;
  logic z_clk, z_rst;
  logic stall_i, flush_i, debug_mode_valid_i;
  logic [31:0] pc_i, instr_i, branch_pc_i, ld_sd_addr_i, data_mem_max_addr_i, csr_mtvec_i;
  logic branch_valid_i, invalid_instr_valid_i, breakpoint_valid_i, ecall_valid_i;
  logic ld_valid_i, sd_valid_i, mem_addr_invalid_i, trap_ack_i, exc_cnt_clr_i;
  logic [1:0] byte_sel_i;
  logic trap_req_o, double_fault_o;
  logic [7:0] trap_cause_o;
  logic [31:0] trap_tval_o, trap_epc_o, trap_handler_addr_o;
  logic [15:0] exc_count_o;
  int checks = 0, failures = 0;
  bit m_pend, m_df;
  logic [7:0] m_cause;
  logic [31:0] m_tval, m_epc;
  int m_cnt;

  z_exception_unit #(.VEC_EXC(1)) dut (
    .z_clk(z_clk), .z_rst(z_rst), .stall_i(stall_i), .flush_i(flush_i),
    .debug_mode_valid_i(debug_mode_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .branch_valid_i(branch_valid_i), .branch_pc_i(branch_pc_i),
    .invalid_instr_valid_i(invalid_instr_valid_i), .breakpoint_valid_i(breakpoint_valid_i),
    .ecall_valid_i(ecall_valid_i), .ld_valid_i(ld_valid_i), .sd_valid_i(sd_valid_i),
    .ld_sd_addr_i(ld_sd_addr_i), .byte_sel_i(byte_sel_i), .mem_addr_invalid_i(mem_addr_invalid_i),
    .data_mem_max_addr_i(data_mem_max_addr_i), .csr_mtvec_i(csr_mtvec_i), .trap_ack_i(trap_ack_i),
    .exc_cnt_clr_i(exc_cnt_clr_i), .trap_req_o(trap_req_o), .trap_cause_o(trap_cause_o),
    .trap_tval_o(trap_tval_o), .trap_epc_o(trap_epc_o), .trap_handler_addr_o(trap_handler_addr_o),
    .double_fault_o(double_fault_o), .exc_count_o(exc_count_o));

  initial begin
    z_clk = 0;
    forever #5 z_clk = ~z_clk;
  end

  task automatic clear_inputs();
    {stall_i, flush_i, debug_mode_valid_i, branch_valid_i, invalid_instr_valid_i} = '0;
    {breakpoint_valid_i, ecall_valid_i, ld_valid_i, sd_valid_i, mem_addr_invalid_i} = '0;
    {trap_ack_i, exc_cnt_clr_i} = '0;
    byte_sel_i = 0; pc_i = 32'h1000; instr_i = 32'h0; branch_pc_i = 0; ld_sd_addr_i = 0;
    data_mem_max_addr_i = 32'h8FFF; csr_mtvec_i = 0;
  endtask

  // Architectural view: first matching source in RISC-V priority order
  task automatic model_source(output bit hit, output logic [7:0] c, output logic [31:0] t);
    bit mis, ld, bad;
    mis = (ld_sd_addr_i % (32'd1 << byte_sel_i)) != 0;
    ld  = ld_valid_i && !stall_i;
    bad = ld_sd_addr_i > data_mem_max_addr_i || mem_addr_invalid_i;
    hit = 1; t = ld_sd_addr_i;
    if (branch_valid_i && branch_pc_i % 4 != 0) begin c = 0; t = branch_pc_i; end
    else if (invalid_instr_valid_i) begin c = 2; t = instr_i; end
    else if (breakpoint_valid_i) begin c = 3; t = pc_i; end
    else if (ecall_valid_i) begin c = 11; t = 0; end
    else if (ld && mis) c = 4;
    else if (sd_valid_i && mis) c = 6;
    else if (ld && bad) c = 5;
    else if (sd_valid_i && bad) c = 7;
    else begin hit = 0; c = 0; end
  endtask

  task automatic cycle();
    bit hit, cap, take;
    logic [7:0] c;
    logic [31:0] t, pc;
    model_source(hit, c, t);
    cap = hit && !flush_i && !debug_mode_valid_i;
    pc = pc_i;
    @(posedge z_clk);
    take = cap && (!m_pend || trap_ack_i);
    if (take) begin
      m_cause = c; m_tval = t; m_epc = pc;
      if (m_cnt < 65535) m_cnt++;
    end
    if (cap && m_pend && !trap_ack_i) m_df = 1;
    if (!take && m_pend && trap_ack_i) m_pend = 0;
    if (take) m_pend = 1;
    if (exc_cnt_clr_i) begin m_cnt = 0; m_df = 0; end
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_df = 0; m_cause = 0; m_tval = 0; m_epc = 0; m_cnt = 0;
  endtask

  task automatic settle();
    clear_inputs();
    trap_ack_i = 1; exc_cnt_clr_i = 1;
    cycle();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    z_rst = 0;
    model_reset();
    #3;
    checks++;
    if ({trap_req_o, double_fault_o, trap_cause_o, trap_tval_o, trap_epc_o, trap_handler_addr_o, exc_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b df=%b cause=%h tval=%h epc=%h hdl=%h cnt=%h required all zero",
               trap_req_o, double_fault_o, trap_cause_o, trap_tval_o, trap_epc_o, trap_handler_addr_o, exc_count_o);
    end
    repeat (2) @(negedge z_clk);
    z_rst = 1;
    @(posedge z_clk); #1;
  endtask

  task automatic test_load_misalign();
    settle();
    ld_valid_i = 1; byte_sel_i = 2'b10; ld_sd_addr_i = 32'h102; pc_i = 32'h2468;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_req_o, trap_cause_o, trap_tval_o, trap_epc_o, exc_count_o} !== {1'b1, 8'd4, 32'h102, 32'h2468, 16'd1}) begin
      failures++;
      $display("FAIL ld_misalign: req=%b cause=%0d tval=%h epc=%h cnt=%0d required 1 4 102 2468 1",
               trap_req_o, trap_cause_o, trap_tval_o, trap_epc_o, exc_count_o);
    end
    trap_ack_i = 1;
    cycle();
    trap_ack_i = 0;
    checks++;
    if (trap_req_o !== 1'b0) begin failures++; $display("FAIL ack_release: req=%b required 0", trap_req_o); end
  endtask

  task automatic test_priority();
    settle();
    invalid_instr_valid_i = 1; instr_i = 32'hDEADBEEF;
    ld_valid_i = 1; byte_sel_i = 2'b01; ld_sd_addr_i = 32'h3;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_cause_o, trap_tval_o} !== {8'd2, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL priority_illegal: cause=%0d tval=%h required 2 deadbeef", trap_cause_o, trap_tval_o);
    end
    settle();
    branch_valid_i = 1; branch_pc_i = 32'h4002; breakpoint_valid_i = 1; ecall_valid_i = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_cause_o, trap_tval_o} !== {8'd0, 32'h4002}) begin
      failures++;
      $display("FAIL priority_imisalign: cause=%0d tval=%h required 0 4002", trap_cause_o, trap_tval_o);
    end
  endtask

  task automatic test_double_fault();
    settle();
    ld_valid_i = 1; byte_sel_i = 2'b10; ld_sd_addr_i = 32'h102;
    cycle();
    clear_inputs();
    ecall_valid_i = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_req_o, trap_cause_o, double_fault_o, exc_count_o} !== {1'b1, 8'd4, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL double_fault: req=%b cause=%0d df=%b cnt=%0d required 1 4 1 1",
               trap_req_o, trap_cause_o, double_fault_o, exc_count_o);
    end
    exc_cnt_clr_i = 1; ecall_valid_i = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({double_fault_o, exc_count_o, trap_req_o} !== {1'b0, 16'd0, 1'b1}) begin
      failures++;
      $display("FAIL clear_wins: df=%b cnt=%0d req=%b required 0 0 1", double_fault_o, exc_count_o, trap_req_o);
    end
  endtask

  task automatic test_back_to_back();
    settle();
    ld_valid_i = 1; byte_sel_i = 2'b10; ld_sd_addr_i = 32'h102;
    cycle();
    clear_inputs();
    trap_ack_i = 1; sd_valid_i = 1; byte_sel_i = 2'b10; ld_sd_addr_i = 32'h9000;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_req_o, trap_cause_o, trap_tval_o, exc_count_o} !== {1'b1, 8'd7, 32'h9000, 16'd2}) begin
      failures++;
      $display("FAIL back_to_back: req=%b cause=%0d tval=%h cnt=%0d required 1 7 9000 2",
               trap_req_o, trap_cause_o, trap_tval_o, exc_count_o);
    end
  endtask

  task automatic test_vectored();
    settle();
    csr_mtvec_i = 32'h2001; ecall_valid_i = 1;
    cycle();
    ecall_valid_i = 0;
    checks++;
    if ({trap_cause_o, trap_handler_addr_o} !== {8'd11, 32'h202C}) begin
      failures++;
      $display("FAIL vectored: cause=%0d hdl=%h required 11 202c", trap_cause_o, trap_handler_addr_o);
    end
    csr_mtvec_i = 32'h2003; #1;
    checks++;
    if (trap_handler_addr_o !== 32'h2000) begin
      failures++; $display("FAIL mode11_base: hdl=%h required 2000", trap_handler_addr_o);
    end
    csr_mtvec_i = 32'h3000; #1;
    checks++;
    if (trap_handler_addr_o !== 32'h3000) begin
      failures++; $display("FAIL direct_base: hdl=%h required 3000", trap_handler_addr_o);
    end
  endtask

  task automatic test_suppress();
    settle();
    ecall_valid_i = 1; flush_i = 1;
    cycle();
    flush_i = 0; debug_mode_valid_i = 1;
    cycle();
    clear_inputs();
    ld_valid_i = 1; stall_i = 1; byte_sel_i = 2'b11; ld_sd_addr_i = 32'h104;
    cycle();
    clear_inputs();
    checks++;
    if ({trap_req_o, exc_count_o} !== {1'b0, 16'd0}) begin
      failures++; $display("FAIL suppress: req=%b cnt=%0d required 0 0", trap_req_o, exc_count_o);
    end
  endtask

  task automatic test_saturate();
    settle();
    trap_ack_i = 1; ld_valid_i = 1; byte_sel_i = 2'b01; ld_sd_addr_i = 32'h1;
    repeat (65536) cycle();
    checks++;
    if (exc_count_o !== 16'hFFFF) begin
      failures++; $display("FAIL saturate: cnt=%h required ffff", exc_count_o);
    end
    cycle();
    clear_inputs();
    checks++;
    if (exc_count_o !== 16'hFFFF) begin
      failures++; $display("FAIL saturate_hold: cnt=%h required ffff", exc_count_o);
    end
  endtask

  task automatic test_reset_mid_pending();
    settle();
    ecall_valid_i = 1;
    cycle();
    clear_inputs();
    #2 z_rst = 0;
    model_reset();
    #1;
    checks++;
    if ({trap_req_o, trap_cause_o, exc_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid_pending: req=%b cause=%0d cnt=%0d required 0 0 0", trap_req_o, trap_cause_o, exc_count_o);
    end
    @(negedge z_clk);
    z_rst = 1;
    @(posedge z_clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] exp_hdl;
    for (int i = 0; i < 1500; i++) begin
      stall_i = $urandom_range(0, 4) == 0; flush_i = $urandom_range(0, 9) == 0;
      debug_mode_valid_i = $urandom_range(0, 9) == 0;
      pc_i = $urandom; instr_i = $urandom; branch_pc_i = $urandom;
      branch_valid_i = $urandom_range(0, 7) == 0; invalid_instr_valid_i = $urandom_range(0, 9) == 0;
      breakpoint_valid_i = $urandom_range(0, 9) == 0; ecall_valid_i = $urandom_range(0, 9) == 0;
      ld_valid_i = $urandom_range(0, 2) == 0; sd_valid_i = $urandom_range(0, 2) == 0;
      byte_sel_i = 2'($urandom); mem_addr_invalid_i = $urandom_range(0, 7) == 0;
      ld_sd_addr_i = ($urandom_range(0, 1) ? 32'h8FF0 : 32'h100) + $urandom_range(0, 31);
      data_mem_max_addr_i = 32'h8FFF; csr_mtvec_i = $urandom;
      trap_ack_i = $urandom_range(0, 1); exc_cnt_clr_i = $urandom_range(0, 19) == 0;
      cycle();
      exp_hdl = (csr_mtvec_i & ~32'h3) + (csr_mtvec_i[1:0] == 2'b01 ? 32'(m_cause) * 4 : 0);
      checks++;
      if ({trap_req_o, trap_cause_o, trap_tval_o, trap_epc_o, double_fault_o, exc_count_o, trap_handler_addr_o} !==
          {m_pend, m_cause, m_tval, m_epc, m_df, 16'(m_cnt), exp_hdl}) begin
        failures++;
        $display("FAIL random[%0d]: req=%b cause=%0d tval=%h epc=%h df=%b cnt=%0d hdl=%h required %b %0d %h %h %b %0d %h",
                 i, trap_req_o, trap_cause_o, trap_tval_o, trap_epc_o, double_fault_o, exc_count_o, trap_handler_addr_o,
                 m_pend, m_cause, m_tval, m_epc, m_df, m_cnt, exp_hdl);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_misalign();
    test_priority();
    test_double_fault();
    test_back_to_back();
    test_vectored();
    test_suppress();
    test_saturate();
    test_reset_mid_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z_exception_unit.md
Name: z_exception_unit

Overview:
- Next-generation, parametrised exception detector plus trap-record capture for the Zilla core.
- Resolves all execute-stage exception sources with fixed RISC-V priority and latches mcause, mtval and mepc into a holding register.
- Presents the latched record to the trap/CSR controller through a req/ack handshake, with optional vectored handler addressing.
- Adds a saturating exception counter and a sticky double-fault flag.

Parameters:
- DATA_WIDTH, 32, data/address/CSR width (32 or 64).
- PC_WIDTH, 32, program counter width.
- CAUSE_WIDTH, 8, width of the cause field.
- CNT_WIDTH, 16, exception counter width.
- VEC_EXC, 0, 1 = vectored handler address for exceptions when mtvec.MODE=01.

Ports:
- z_clk  in  1  clock
- z_rst  in  1  reset
- stall_i  in  1  pipeline stall; masks load/store sources
- flush_i  in  1  squashes the current-cycle capture
- debug_mode_valid_i  in  1  core in debug mode; suppresses capture
- pc_i  in  PC_WIDTH  PC of the execute-stage instruction
- instr_i  in  32  execute-stage instruction word
- branch_valid_i  in  1  branch/jump taken
- branch_pc_i  in  PC_WIDTH  branch target
- invalid_instr_valid_i  in  1  illegal instruction
- breakpoint_valid_i  in  1  EBREAK
- ecall_valid_i  in  1  ECALL
- ld_valid_i  in  1  load in execute
- sd_valid_i  in  1  store in execute
- ld_sd_addr_i  in  DATA_WIDTH  effective address
- byte_sel_i  in  2  00 byte, 01 half, 10 word, 11 double
- mem_addr_invalid_i  in  1  external access-fault indication
- data_mem_max_addr_i  in  DATA_WIDTH  highest legal data address
- csr_mtvec_i  in  DATA_WIDTH  mtvec CSR
- trap_ack_i  in  1  trap controller consumed record
- exc_cnt_clr_i  in  1  clears counter and double-fault flag
- trap_req_o  out  1  record valid, awaiting ack
- trap_cause_o  out  CAUSE_WIDTH  latched mcause
- trap_tval_o  out  DATA_WIDTH  latched mtval
- trap_epc_o  out  PC_WIDTH  latched mepc
- trap_handler_addr_o  out  DATA_WIDTH  handler target
- double_fault_o  out  1  sticky: exception detected while a record was pending
- exc_count_o  out  CNT_WIDTH  captured-exception count

Behaviour:
- Reset: reset z_rst, asynchronous, active-low; clock z_clk. All outputs are 0 and the FSM is in IDLE.
- Source detection is combinational:
  - Instr misalign: branch_valid_i and branch_pc_i[1:0] != 0.
  - Load/store misalign: the byte_sel_i-selected low address bits are nonzero (byte never misaligns). Load is gated by !stall_i; store is not.
  - Access fault: ld_sd_addr_i > data_mem_max_addr_i or mem_addr_invalid_i, on a valid load/store that is not misaligned.
- Priority, highest first, with (cause, tval):
  - instr misalign: 0, branch_pc_i
  - illegal: 2, instr_i
  - breakpoint: 3, pc_i
  - ecall: 11, 0
  - load misalign: 4, addr
  - store misalign: 6, addr
  - load fault: 5, addr
  - store fault: 7, addr
- Multiple simultaneous sources are legal; the highest-priority source wins. This replaces the one-hot behaviour.
- Breakpoint raises a trap.
- tval values are zero-extended to DATA_WIDTH; epc = pc_i.
- capture = any source & !flush_i & !debug_mode_valid_i.
- FSM IDLE/PENDING:
  - IDLE & capture: latch the record and go to PENDING. trap_req_o is high from the next cycle (1-cycle latency).
  - PENDING & trap_ack_i & !capture: go to IDLE; trap_req_o low the next cycle.
  - PENDING & trap_ack_i & capture: relatch the new record and stay in PENDING (back-to-back, no bubble).
  - PENDING & !trap_ack_i & capture: record unchanged; double_fault_o set sticky; counter not incremented.
  - The record is stable while trap_req_o is high and not acked.
- Handler address:
  - Base = {mtvec[DATA_WIDTH-1:2], 00}, sampled combinationally.
  - If VEC_EXC=1 and mtvec[1:0]=01: base + (trap_cause_o << 2).
  - Otherwise, including modes 10/11: base.
- Counter:
  - Increments on every latch (IDLE capture or ack+capture).
  - Saturates at all-ones.
  - exc_cnt_clr_i clears the counter and double_fault_o, and wins over a same-cycle increment or set.
- Reset asserted mid-PENDING drops the record immediately.

Test Plan:
- ld_valid, byte_sel=10, addr=0x102, stall=0 -> next cycle trap_req=1, cause=4, tval=0x102, count=1; ack -> trap_req=0 the following cycle.
- illegal + ld misalign (addr 0x3, half) in the same cycle -> cause=2, tval=instr_i.
- PENDING, no ack, ecall pulse -> cause unchanged, double_fault=1, count unchanged; exc_cnt_clr -> double_fault=0, count=0.
- PENDING, ack in the same cycle as sd to 0x9000 with max 0x8FFF -> trap_req stays 1, cause=7, tval=0x9000, count+1.
- VEC_EXC=1, mtvec=0x2001, ecall -> handler=0x202C; mtvec=0x2003 -> handler=0x2000.
- Exception with flush_i=1 or debug_mode_valid_i=1 -> no trap_req; ld misalign with stall_i=1 -> none. Count held at max 0xFFFF plus another capture -> stays 0xFFFF.
